keypad_scanner: RTL and testbench

//  Input-side counterpart of the display path: scans a 4x4 matrix keypad, debounces

---
 rtl/keypad_scanner.sv | 146 ++++++++++++++
 tb/tb_keypad_scanner.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one column driven low per dwell period, rows debounced per tick,
// one key_code/key_valid per physical press; key must be fully released before the next press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_TGT   = CW'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    cand_row_q, cand_row_d;
  logic [CW-1:0] deb_q, deb_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;
  logic [3:0]    sync1_q, rows_s_q;

  logic          tick;
  logic [1:0]    first_low;
  logic          cand_low;
  logic [CW-1:0] deb_inc;

  assign tick     = (dwell_q == DWELL_MAX);
  assign cand_low = ~rows_s_q[cand_row_q];
  assign deb_inc  = deb_q + CW'(1);

  // Lowest-index pressed row wins when several rows are low together.
  always_comb begin
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_s_q[i]) first_low = 2'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    dwell_d     = tick ? '0 : dwell_q + DW'(1);
    col_d       = col_q;
    cand_row_d  = cand_row_q;
    deb_d       = deb_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (rows_s_q == 4'hF) begin
            col_d = col_q + 2'd1;
          end else begin
            cand_row_d = first_low;
            if (DEB_TGT == CW'(1)) begin
              key_code_d  = {first_low, col_q};
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              deb_d       = '0;
              state_d     = HOLD;
            end else begin
              deb_d   = CW'(1);
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (cand_low) begin
            if (deb_inc == DEB_TGT) begin
              key_code_d  = {cand_row_q, col_q};
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              deb_d       = '0;
              state_d     = HOLD;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            col_d   = col_q + 2'd1;
            deb_d   = '0;
            state_d = SCAN;
          end
        end
        HOLD: begin
          // Column stays parked on the accepted key, so other columns cannot report roll-over.
          if (rows_s_q == 4'hF) begin
            if (deb_inc == DEB_TGT) begin
              key_down_d = 1'b0;
              col_d      = col_q + 2'd1;
              deb_d      = '0;
              state_d    = SCAN;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            deb_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= SCAN;
      dwell_q     <= '0;
      col_q       <= 2'd0;
      cand_row_q  <= 2'd0;
      deb_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      sync1_q     <= 4'hF;
      rows_s_q    <= 4'hF;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      cand_row_q  <= cand_row_d;
      deb_q       <= deb_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      sync1_q     <= row_in;
      rows_s_q    <= sync1_q;
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a row/column keypad model and a key-code scoreboard.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [15:0] pressed = '0;
  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int cyc = 0;
  int last_pulse_cyc = 0;
  logic valid_prev = 1'b0;
  logic [4:0] exp_q[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk(clk), .clear(clear), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key (r,c) shorts row r to column c; rows are pulled high otherwise.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    if (valid_prev) chk("valid_width", {31'd0, key_valid}, 32'd0);
    if (key_valid === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h10;
      chk("sb_code", {27'd0, 1'b0, key_code}, {27'd0, e});
    end
    valid_prev = key_valid;
  end

  task automatic wait_pulses(input int n, input string tag);
    for (int i = 0; i < 200 && pulse_cnt < n; i++) @(negedge clk);
    chk(tag, pulse_cnt, n);
  endtask

  task automatic wait_release(input string tag);
    for (int i = 0; i < 100 && key_down !== 1'b0; i++) @(negedge clk);
    chk(tag, {31'd0, key_down}, 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_col"},   {28'd0, col_out},  32'h0000000E);
    chk({tag, "_code"},  {28'd0, key_code}, 32'd0);
    chk({tag, "_valid"}, {31'd0, key_valid}, 32'd0);
    chk({tag, "_down"},  {31'd0, key_down},  32'd0);
  endtask

  initial begin
    int base;
    int prev_pulse;
    logic [3:0] exp_col;
    clear = 1'b1;
    // 1: reset values and idle column rotation
    repeat (5) @(negedge clk);
    clear = 1'b0;
    chk_reset_outs("rst");
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      chk("rotate_col", {28'd0, col_out}, {28'd0, exp_col});
    end

    // 2: steady key row2/col1
    base = pulse_cnt;
    exp_q.push_back(5'd9);
    pressed[9] = 1'b1;
    wait_pulses(base + 1, "k9_pulse");
    @(negedge clk);
    chk("k9_down", {31'd0, key_down}, 32'd1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k % 10 == 0) chk("k9_col_hold", {28'd0, col_out}, 32'h0000000D);
    end
    chk("k9_single", pulse_cnt, base + 1);
    pressed[9] = 1'b0;
    wait_release("k9_release");
    chk("k9_resume_col", {28'd0, col_out}, 32'h0000000B);

    // 3: bouncing key row1/col3, then stable
    repeat (8) @(negedge clk);
    base = pulse_cnt;
    for (int k = 0; k < 12; k++) begin
      pressed[7] = (k % 2 == 0);
      repeat (4) @(negedge clk);
    end
    chk("k7_no_bounce_pulse", pulse_cnt, base);
    exp_q.push_back(5'd7);
    pressed[7] = 1'b1;
    wait_pulses(base + 1, "k7_pulse");
    pressed[7] = 1'b0;
    wait_release("k7_release");

    // 4: two keys in column 2, then a lockout press in column 0
    repeat (8) @(negedge clk);
    base = pulse_cnt;
    exp_q.push_back(5'd2);
    pressed[2] = 1'b1;
    pressed[14] = 1'b1;
    wait_pulses(base + 1, "k2_pulse");
    pressed[4] = 1'b1;
    repeat (40) @(negedge clk);
    chk("lockout_no_pulse", pulse_cnt, base + 1);
    pressed = '0;
    wait_release("k2_release");
    repeat (8) @(negedge clk);
    exp_q.push_back(5'd4);
    pressed[4] = 1'b1;
    wait_pulses(base + 2, "k4_repress");
    pressed = '0;
    wait_release("k4_release");

    // 5: clear during DEBOUNCE after two good ticks, and during HOLD
    base = pulse_cnt;
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    pressed[0] = 1'b1;
    repeat (9) @(negedge clk);
    clear = 1'b1;
    pressed = '0;
    @(negedge clk);
    clear = 1'b0;
    chk_reset_outs("clr_deb");
    repeat (40) @(negedge clk);
    chk("clr_deb_no_pulse", pulse_cnt, base);
    chk("clr_deb_code", {28'd0, key_code}, 32'd0);
    exp_q.push_back(5'd5);
    pressed[5] = 1'b1;
    wait_pulses(base + 1, "k5_pulse");
    repeat (6) @(negedge clk);
    clear = 1'b1;
    pressed = '0;
    @(negedge clk);
    clear = 1'b0;
    chk_reset_outs("clr_hold");
    repeat (30) @(negedge clk);
    chk("clr_hold_no_pulse", pulse_cnt, base + 1);

    // 6: key 15 pressed and released four times
    base = pulse_cnt;
    prev_pulse = 0;
    for (int n = 1; n <= 4; n++) begin
      exp_q.push_back(5'd15);
      pressed[15] = 1'b1;
      wait_pulses(base + n, "k15_pulse");
      if (n > 1) chk("k15_spacing", {31'd0, (last_pulse_cyc - prev_pulse) >= 24}, 32'd1);
      prev_pulse = last_pulse_cyc;
      pressed[15] = 1'b0;
      wait_release("k15_release");
      repeat (8) @(negedge clk);
    end
    chk("k15_total", pulse_cnt, base + 4);
    chk("k15_code", {28'd0, key_code}, 32'h0000000F);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
